// File: rtl/td4_pkg.sv
// Shared encodings for the TD4 sequencer: opcodes, source selects, active-low
// load masks and the controller state type.
package td4_pkg;

    localparam logic [3:0] OP_ADD_A   = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B = 4'b0001;
    localparam logic [3:0] OP_IN_A    = 4'b0010;
    localparam logic [3:0] OP_MOV_A   = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A = 4'b0100;
    localparam logic [3:0] OP_ADD_B   = 4'b0101;
    localparam logic [3:0] OP_IN_B    = 4'b0110;
    localparam logic [3:0] OP_MOV_B   = 4'b0111;
    localparam logic [3:0] OP_OUT_B   = 4'b1001;
    localparam logic [3:0] OP_OUT_IM  = 4'b1011;
    localparam logic [3:0] OP_JNC     = 4'b1110;
    localparam logic [3:0] OP_JMP     = 4'b1111;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam logic [3:0] LD_A    = 4'b1110;
    localparam logic [3:0] LD_B    = 4'b1101;
    localparam logic [3:0] LD_OUT  = 4'b1011;
    localparam logic [3:0] LD_PC   = 4'b0111;
    localparam logic [3:0] LD_NONE = 4'b1111;

    typedef enum logic [1:0] {
        HALT   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        EXEC   = 2'd3
    } state_t;

endpackage

// File: rtl/td4_decode.sv
// Combinational TD4 opcode decoder: maps opcode and carry_n to the register
// load mask, source select and an undefined-opcode indication.
module td4_decode
    import td4_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       carry_n,
    output logic [3:0] load_n,
    output logic [1:0] select,
    output logic       illegal
);

    always_comb begin
        load_n  = LD_NONE;
        select  = SEL_ZERO;
        illegal = 1'b0;
        case (opcode)
            OP_ADD_A:   begin select = SEL_A;    load_n = LD_A;   end
            OP_ADD_B:   begin select = SEL_B;    load_n = LD_B;   end
            OP_MOV_A:   begin select = SEL_ZERO; load_n = LD_A;   end
            OP_MOV_B:   begin select = SEL_ZERO; load_n = LD_B;   end
            OP_MOV_A_B: begin select = SEL_B;    load_n = LD_A;   end
            OP_MOV_B_A: begin select = SEL_A;    load_n = LD_B;   end
            OP_IN_A:    begin select = SEL_IN;   load_n = LD_A;   end
            OP_IN_B:    begin select = SEL_IN;   load_n = LD_B;   end
            OP_OUT_B:   begin select = SEL_B;    load_n = LD_OUT; end
            OP_OUT_IM:  begin select = SEL_ZERO; load_n = LD_OUT; end
            OP_JMP:     begin select = SEL_ZERO; load_n = LD_PC;  end
            // Untaken JNC leaves every load high so the PC simply increments.
            OP_JNC: begin
                select = SEL_ZERO;
                if (carry_n) load_n = LD_PC;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 fetch/decode/execute controller with run, single-step, halt request,
// breakpoint and executed-instruction counting. All outputs are registered.
module td4_sequencer
    import td4_pkg::*;
#(
    parameter int ROM_LATENCY     = 1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       RUN,
    input  logic       STEP,
    input  logic       HALT_REQ,
    input  logic       BKPT_EN,
    input  logic [3:0] BKPT_ADDR,
    input  logic [3:0] PC,
    input  logic [7:0] ROM_DATA,
    input  logic       CARRY_N,
    output logic       REG_CE,
    output logic [3:0] LOAD_N,
    output logic [1:0] SELECT,
    output logic [3:0] IMMED,
    output logic       HALTED,
    output logic       ILLEGAL,
    output logic       BKPT_HIT,
    output logic [7:0] INSTR_CNT
);

    localparam logic [1:0] LAT_LAST = 2'(ROM_LATENCY - 1);

    state_t     state_q, state_d;
    logic [1:0] lat_q, lat_d;
    logic [7:0] instr_q, instr_d;
    logic       step_q, step_d;
    logic       resume_q, resume_d;
    logic       halt_lat_q, halt_lat_d;
    logic       ill_new_q, ill_new_d;
    logic       reg_ce_q, reg_ce_d;
    logic [3:0] load_n_q, load_n_d;
    logic [1:0] select_q, select_d;
    logic [3:0] immed_q, immed_d;
    logic       halted_q, halted_d;
    logic       illegal_q, illegal_d;
    logic       bkpt_q, bkpt_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] dec_load_n;
    logic [1:0] dec_select;
    logic       dec_illegal;

    td4_decode u_decode (
        .opcode  (instr_q[7:4]),
        .carry_n (CARRY_N),
        .load_n  (dec_load_n),
        .select  (dec_select),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        instr_d    = instr_q;
        step_d     = step_q;
        resume_d   = resume_q;
        ill_new_d  = ill_new_q;
        reg_ce_d   = 1'b0;
        load_n_d   = LD_NONE;
        select_d   = select_q;
        immed_d    = immed_q;
        illegal_d  = illegal_q;
        bkpt_d     = bkpt_q;
        cnt_d      = cnt_q;
        halt_lat_d = halt_lat_q | (HALT_REQ && (state_q != HALT));

        case (state_q)
            HALT: begin
                if (RUN || STEP) begin
                    state_d  = FETCH;
                    step_d   = ~RUN;
                    resume_d = 1'b1;
                    bkpt_d   = 1'b0;
                    lat_d    = 2'd0;
                end
            end
            FETCH: begin
                // The resume flag lets execution restart on the breakpoint address.
                if ((lat_q == 2'd0) && BKPT_EN && (PC == BKPT_ADDR) && !resume_q) begin
                    state_d = HALT;
                    bkpt_d  = 1'b1;
                end else if (lat_q == LAT_LAST) begin
                    instr_d  = ROM_DATA;
                    state_d  = DECODE;
                    resume_d = 1'b0;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            DECODE: begin
                state_d   = EXEC;
                reg_ce_d  = 1'b1;
                load_n_d  = dec_load_n;
                select_d  = dec_select;
                immed_d   = instr_q[3:0];
                ill_new_d = dec_illegal && !illegal_q;
                illegal_d = illegal_q | dec_illegal;
                cnt_d     = cnt_q + 8'd1;
            end
            EXEC: begin
                lat_d = 2'd0;
                if (step_q || !RUN || halt_lat_q || HALT_REQ || (ill_new_q && HALT_ON_ILLEGAL))
                    state_d = HALT;
                else
                    state_d = FETCH;
            end
            default: state_d = HALT;
        endcase

        if (state_d == HALT) halt_lat_d = 1'b0;
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state_q    <= HALT;
            lat_q      <= 2'd0;
            instr_q    <= 8'd0;
            step_q     <= 1'b0;
            resume_q   <= 1'b0;
            halt_lat_q <= 1'b0;
            ill_new_q  <= 1'b0;
            reg_ce_q   <= 1'b0;
            load_n_q   <= LD_NONE;
            select_q   <= SEL_ZERO;
            immed_q    <= 4'd0;
            halted_q   <= 1'b1;
            illegal_q  <= 1'b0;
            bkpt_q     <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            instr_q    <= instr_d;
            step_q     <= step_d;
            resume_q   <= resume_d;
            halt_lat_q <= halt_lat_d;
            ill_new_q  <= ill_new_d;
            reg_ce_q   <= reg_ce_d;
            load_n_q   <= load_n_d;
            select_q   <= select_d;
            immed_q    <= immed_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
            bkpt_q     <= bkpt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign REG_CE    = reg_ce_q;
    assign LOAD_N    = load_n_q;
    assign SELECT    = select_q;
    assign IMMED     = immed_q;
    assign HALTED    = halted_q;
    assign ILLEGAL   = illegal_q;
    assign BKPT_HIT  = bkpt_q;
    assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// Bench for td4_sequencer: a small PC/ROM datapath model, a strobe scoreboard
// and a decode vector table plus hand-written debug-control sequences.
module tb_td4_sequencer;

    logic       CLK = 1'b0;
    logic       CLR_N, RUN, STEP, HALT_REQ, BKPT_EN, CARRY_N;
    logic [3:0] BKPT_ADDR;
    logic [3:0] pc;
    logic [7:0] ROM_DATA;
    logic       REG_CE, HALTED, ILLEGAL, BKPT_HIT;
    logic [3:0] LOAD_N, IMMED;
    logic [1:0] SELECT;
    logic [7:0] INSTR_CNT;

    logic [7:0] rom [16];
    assign ROM_DATA = rom[pc];

    td4_sequencer #(.ROM_LATENCY(1), .HALT_ON_ILLEGAL(1'b1)) dut (
        .CLK(CLK), .CLR_N(CLR_N), .RUN(RUN), .STEP(STEP), .HALT_REQ(HALT_REQ),
        .BKPT_EN(BKPT_EN), .BKPT_ADDR(BKPT_ADDR), .PC(pc), .ROM_DATA(ROM_DATA),
        .CARRY_N(CARRY_N), .REG_CE(REG_CE), .LOAD_N(LOAD_N), .SELECT(SELECT),
        .IMMED(IMMED), .HALTED(HALTED), .ILLEGAL(ILLEGAL), .BKPT_HIT(BKPT_HIT),
        .INSTR_CNT(INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] load_n;
        logic [1:0] sel;
        logic [3:0] imm;
    } exp_t;

    typedef struct {
        logic [7:0] instr;
        logic       carry_n;
        logic [3:0] load_n;
        logic [1:0] sel;
        logic       ill;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   ce_count = 0;

    // Datapath model: PC loads the immediate (zero + IMMED) or increments on each strobe.
    always @(posedge CLK) begin
        if (!CLR_N)
            pc <= 4'd0;
        else if (REG_CE)
            pc <= LOAD_N[3] ? pc + 4'd1 : IMMED;
    end

    always @(negedge CLK) begin
        if (REG_CE === 1'b1) begin
            ce_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe actual LOAD_N=%b SELECT=%b IMMED=%h required no strobe",
                         LOAD_N, SELECT, IMMED);
            end else begin
                mon_e = exp_q.pop_front();
                if ({LOAD_N, SELECT, IMMED} !== mon_e) begin
                    failures++;
                    $display("FAIL strobe_ctrl actual LOAD_N=%b SELECT=%b IMMED=%h required LOAD_N=%b SELECT=%b IMMED=%h",
                             LOAD_N, SELECT, IMMED, mon_e.load_n, mon_e.sel, mon_e.imm);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_ce(input int budget, output int cyc);
        cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if (REG_CE === 1'b1) begin
                cyc = i;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL strobe_timeout actual=none required=strobe within %0d cycles", budget);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_reg_ce"}, 32'(REG_CE), 32'd0);
        chk({tag, "_load_n"}, 32'(LOAD_N), 32'hF);
        chk({tag, "_select"}, 32'(SELECT), 32'h3);
        chk({tag, "_immed"}, 32'(IMMED), 32'h0);
        chk({tag, "_halted"}, 32'(HALTED), 32'd1);
        chk({tag, "_illegal"}, 32'(ILLEGAL), 32'd0);
        chk({tag, "_bkpt_hit"}, 32'(BKPT_HIT), 32'd0);
        chk({tag, "_instr_cnt"}, 32'(INSTR_CNT), 32'd0);
    endtask

    vec_t vecs[17];
    int   cyc;
    int   exp_cnt;
    logic exp_ill;
    int   ce_before;
    bit   got_halt;

    initial begin
        vecs[0]  = '{8'h35, 1'b1, 4'b1110, 2'b11, 1'b0};
        vecs[1]  = '{8'h02, 1'b1, 4'b1110, 2'b00, 1'b0};
        vecs[2]  = '{8'h5A, 1'b1, 4'b1101, 2'b01, 1'b0};
        vecs[3]  = '{8'h7C, 1'b1, 4'b1101, 2'b11, 1'b0};
        vecs[4]  = '{8'h10, 1'b1, 4'b1110, 2'b01, 1'b0};
        vecs[5]  = '{8'h40, 1'b1, 4'b1101, 2'b00, 1'b0};
        vecs[6]  = '{8'h23, 1'b1, 4'b1110, 2'b10, 1'b0};
        vecs[7]  = '{8'h61, 1'b1, 4'b1101, 2'b10, 1'b0};
        vecs[8]  = '{8'h96, 1'b1, 4'b1011, 2'b01, 1'b0};
        vecs[9]  = '{8'hB7, 1'b1, 4'b1011, 2'b11, 1'b0};
        vecs[10] = '{8'hF4, 1'b1, 4'b0111, 2'b11, 1'b0};
        vecs[11] = '{8'hE9, 1'b0, 4'b1111, 2'b11, 1'b0};
        vecs[12] = '{8'hE9, 1'b1, 4'b0111, 2'b11, 1'b0};
        vecs[13] = '{8'h80, 1'b1, 4'b1111, 2'b11, 1'b1};
        vecs[14] = '{8'hA5, 1'b0, 4'b1111, 2'b11, 1'b1};
        vecs[15] = '{8'hC0, 1'b1, 4'b1111, 2'b11, 1'b1};
        vecs[16] = '{8'hD3, 1'b1, 4'b1111, 2'b11, 1'b1};
        for (int i = 0; i < 16; i++) rom[i] = 8'hB0;

        CLR_N = 1'b0; RUN = 1'b0; STEP = 1'b0; HALT_REQ = 1'b0;
        BKPT_EN = 1'b0; BKPT_ADDR = 4'd0; CARRY_N = 1'b1;
        repeat (2) tick();
        check_reset_outputs("reset");
        CLR_N = 1'b1;
        tick();
        chk("idle_halted", 32'(HALTED), 32'd1);

        // Free run of MOV A,5 then RUN dropped inside EXEC.
        rom[0] = 8'h35;
        exp_q.push_back('{4'b1110, 2'b11, 4'h5});
        RUN = 1'b1;
        wait_ce(10, cyc);
        chk("run_latency", 32'(cyc), 32'd3);
        RUN = 1'b0;
        tick();
        chk("run_cnt", 32'(INSTR_CNT), 32'd1);
        chk("run_drop_halted", 32'(HALTED), 32'd1);
        exp_cnt = 1;
        exp_ill = 1'b0;

        // Single-step decode table.
        for (int i = 0; i < 17; i++) begin
            rom[pc] = vecs[i].instr;
            CARRY_N = vecs[i].carry_n;
            exp_q.push_back('{vecs[i].load_n, vecs[i].sel, vecs[i].instr[3:0]});
            STEP = 1'b1;
            tick();
            STEP = 1'b0;
            wait_ce(10, cyc);
            chk($sformatf("step_latency_%0d", i), 32'(cyc + 1), 32'd3);
            tick();
            exp_cnt++;
            exp_ill = exp_ill | vecs[i].ill;
            chk($sformatf("step_halted_%0d", i), 32'(HALTED), 32'd1);
            chk($sformatf("step_cnt_%0d", i), 32'(INSTR_CNT), 32'(exp_cnt));
            chk($sformatf("step_illegal_%0d", i), 32'(ILLEGAL), 32'(exp_ill));
        end
        CARRY_N = 1'b1;

        // Breakpoint at address 3, then resume past it.
        CLR_N = 1'b0;
        tick();
        CLR_N = 1'b1;
        rom[0] = 8'hB1; rom[1] = 8'hB2; rom[2] = 8'hB3; rom[3] = 8'h74;
        rom[4] = 8'hB9; rom[5] = 8'h80; rom[6] = 8'h3A;
        exp_q.push_back('{4'b1011, 2'b11, 4'h1});
        exp_q.push_back('{4'b1011, 2'b11, 4'h2});
        exp_q.push_back('{4'b1011, 2'b11, 4'h3});
        BKPT_EN = 1'b1; BKPT_ADDR = 4'd3; RUN = 1'b1;
        got_halt = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (HALTED === 1'b1) begin
                RUN = 1'b0;
                got_halt = 1'b1;
                break;
            end
        end
        chk("bkpt_halt_seen", 32'(got_halt), 32'd1);
        chk("bkpt_hit", 32'(BKPT_HIT), 32'd1);
        chk("bkpt_pc", 32'(pc), 32'd3);
        chk("bkpt_cnt", 32'(INSTR_CNT), 32'd3);
        chk("bkpt_pending", 32'(exp_q.size()), 32'd0);
        tick();
        chk("bkpt_stays_halted", 32'(HALTED), 32'd1);
        exp_q.push_back('{4'b1101, 2'b11, 4'h4});
        RUN = 1'b1;
        wait_ce(10, cyc);
        RUN = 1'b0;
        chk("bkpt_resume_latency", 32'(cyc), 32'd3);
        chk("bkpt_hit_cleared", 32'(BKPT_HIT), 32'd0);
        tick();
        chk("bkpt_resume_halted", 32'(HALTED), 32'd1);
        chk("bkpt_resume_pc", 32'(pc), 32'd4);
        BKPT_EN = 1'b0;

        // Halt request during FETCH with RUN held high.
        exp_q.push_back('{4'b1011, 2'b11, 4'h9});
        RUN = 1'b1;
        tick();
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        wait_ce(10, cyc);
        chk("hreq_latency", 32'(cyc + 2), 32'd3);
        tick();
        chk("hreq_halted", 32'(HALTED), 32'd1);
        RUN = 1'b0;

        // Undefined opcode in free run halts after its strobe.
        exp_q.push_back('{4'b1111, 2'b11, 4'h0});
        RUN = 1'b1;
        wait_ce(10, cyc);
        chk("illegal_flag", 32'(ILLEGAL), 32'd1);
        tick();
        chk("illegal_halted", 32'(HALTED), 32'd1);
        RUN = 1'b0;
        chk("illegal_pc", 32'(pc), 32'd6);

        // Reset asserted during EXEC.
        exp_q.push_back('{4'b1110, 2'b11, 4'hA});
        RUN = 1'b1;
        wait_ce(10, cyc);
        CLR_N = 1'b0;
        RUN = 1'b0;
        tick();
        check_reset_outputs("exec_reset");
        CLR_N = 1'b1;
        ce_before = ce_count;
        repeat (8) tick();
        chk("post_reset_no_strobe", 32'(ce_count), 32'(ce_before));
        chk("post_reset_halted", 32'(HALTED), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
